// File: rtl/sirc_port_pkg.sv
// Shared definitions for the SIRC user-port responder.
//   hostSel_e        : encodings of the host_sel field
//   READ_LATENCY_MIN : smallest supported input-memory read latency
//   READ_LATENCY_MAX : largest supported input-memory read latency
//   COUNT_WIDTH      : width of the output-write counter
//   satInc           : saturating increment for that counter
package sirc_port_pkg;

   typedef enum logic [1:0] {
      HOST_INMEM  = 2'd0,
      HOST_PARAM  = 2'd1,
      HOST_OUTMEM = 2'd2,
      HOST_RUN    = 2'd3
   } hostSel_e;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 4;
   localparam int COUNT_WIDTH      = 16;

   function automatic logic [COUNT_WIDTH-1:0] satInc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sirc_lat_pipe.sv
// Fixed-depth valid/data shift pipe. Every cycle the input pair enters
// stage 0 and the pair in the last stage is presented at the output, so
// a pair entering in cycle t appears at the output in cycle t+DEPTH.
// Reset empties every stage, so nothing in flight survives a reset.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   inValid, inData   : pair entering the pipe
//   outValid, outData : pair leaving the pipe (data is 0 after reset)
module sirc_lat_pipe
   import sirc_port_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inValid,
   input  logic [WIDTH-1:0] inData,
   output logic             outValid,
   output logic [WIDTH-1:0] outData
);

   logic             validPipe [DEPTH];
   logic [WIDTH-1:0] dataPipe  [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            validPipe[i] <= 1'b0;
            dataPipe[i]  <= '0;
         end
      end else begin
         validPipe[0] <= inValid;
         dataPipe[0]  <= inData;
         for (int i = 1; i < DEPTH; i++) begin
            validPipe[i] <= validPipe[i-1];
            dataPipe[i]  <= dataPipe[i-1];
         end
      end
   end

   assign outValid = validPipe[DEPTH-1];
   assign outData  = dataPipe[DEPTH-1];

endmodule

// File: rtl/sirc_user_port_responder.sv
// Responder side of the SIRC user-circuit port. Holds the 256 x 32-bit
// parameter file, the run flag, the input memory (user reads, host writes)
// and the output memory (user writes, host reads), and answers the user
// circuit's handshakes. A host port preloads inputs/parameters, sets run
// and reads results back.
// Ports:
//   clk, reset, stall             : clock, sync active-high reset, ack throttle
//   userRunValue / userRunClear   : run flag and its user-side clear
//   register32*                   : parameter read/write channel
//   inputMemoryRead*              : input-memory read channel
//   outputMemoryWrite*            : output-memory byte-masked write channel
//   host_en/we/sel/addr/wdata     : host access strobe and payload
//   host_rdata                    : host read data, one cycle after the read
//   out_write_count               : output writes since run was last set
//
// Handshake: a transfer happens in any cycle where the user's req and our ack
// are both high; address, data, mask and write-enable are sampled in that
// cycle. Ack is a register loaded with !stall, shared by all three channels,
// so each channel can transfer every cycle while stall stays low.
module sirc_user_port_responder
   import sirc_port_pkg::*;
#(
   parameter int INMEM_BYTE_WIDTH     = 1,
   parameter int OUTMEM_BYTE_WIDTH    = 1,
   parameter int INMEM_ADDRESS_WIDTH  = 17,
   parameter int OUTMEM_ADDRESS_WIDTH = 13,
   parameter int READ_LATENCY         = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            stall,
   output logic                            userRunValue,
   input  logic                            userRunClear,
   input  logic                            register32CmdReq,
   output logic                            register32CmdAck,
   input  logic [7:0]                      register32Address,
   input  logic                            register32WriteEn,
   input  logic [31:0]                     register32WriteData,
   output logic                            register32ReadDataValid,
   output logic [31:0]                     register32ReadData,
   input  logic                            inputMemoryReadReq,
   output logic                            inputMemoryReadAck,
   input  logic [INMEM_ADDRESS_WIDTH-1:0]  inputMemoryReadAdd,
   output logic                            inputMemoryReadDataValid,
   output logic [INMEM_BYTE_WIDTH*8-1:0]   inputMemoryReadData,
   input  logic                            outputMemoryWriteReq,
   output logic                            outputMemoryWriteAck,
   input  logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd,
   input  logic [OUTMEM_BYTE_WIDTH*8-1:0]  outputMemoryWriteData,
   input  logic [OUTMEM_BYTE_WIDTH-1:0]    outputMemoryWriteByteMask,
   input  logic                            host_en,
   input  logic                            host_we,
   input  logic [1:0]                      host_sel,
   input  logic [16:0]                     host_addr,
   input  logic [31:0]                     host_wdata,
   output logic [31:0]                     host_rdata,
   output logic [COUNT_WIDTH-1:0]          out_write_count
);

   localparam int IN_W      = INMEM_BYTE_WIDTH * 8;
   localparam int OUT_W     = OUTMEM_BYTE_WIDTH * 8;
   localparam int IN_DEPTH  = 1 << INMEM_ADDRESS_WIDTH;
   localparam int OUT_DEPTH = 1 << OUTMEM_ADDRESS_WIDTH;

   logic                            ackReg;
   logic                            paramAccept, inAccept, outAccept;
   logic                            hostRead, hostWrInmem, hostWrParam, hostWrRun;
   logic [INMEM_ADDRESS_WIDTH-1:0]  inHostAddr;
   logic [OUTMEM_ADDRESS_WIDTH-1:0] outHostAddr;

   logic [31:0]    params [256];
   logic [IN_W-1:0]  inMem  [IN_DEPTH];
   logic [OUT_W-1:0] outMem [OUT_DEPTH];

   // ---------------- acks and accept decode ----------------
   always_ff @(posedge clk) begin
      if (reset) ackReg <= 1'b0;
      else       ackReg <= !stall;
   end

   assign register32CmdAck     = ackReg;
   assign inputMemoryReadAck   = ackReg;
   assign outputMemoryWriteAck = ackReg;

   assign paramAccept = register32CmdReq     && ackReg;
   assign inAccept    = inputMemoryReadReq   && ackReg;
   assign outAccept   = outputMemoryWriteReq && ackReg;

   assign hostRead    = host_en && !host_we;
   assign hostWrInmem = host_en && host_we && (host_sel == HOST_INMEM);
   assign hostWrParam = host_en && host_we && (host_sel == HOST_PARAM);
   assign hostWrRun   = host_en && host_we && (host_sel == HOST_RUN);

   // Host addresses wrap onto each array's depth.
   assign inHostAddr  = INMEM_ADDRESS_WIDTH'(host_addr);
   assign outHostAddr = OUTMEM_ADDRESS_WIDTH'(host_addr);

   // ---------------- parameter file ----------------
   // Host write is applied after the user write so the host value wins
   // when both target the same index in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) params[i] <= '0;
      end else begin
         if (paramAccept && register32WriteEn)
            params[register32Address] <= register32WriteData;
         if (hostWrParam)
            params[host_addr[7:0]] <= host_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         register32ReadDataValid <= 1'b0;
         register32ReadData      <= '0;
      end else begin
         register32ReadDataValid <= paramAccept && !register32WriteEn;
         if (paramAccept && !register32WriteEn)
            register32ReadData <= params[register32Address];
      end
   end

   // ---------------- input memory ----------------
   always_ff @(posedge clk) begin
      if (hostWrInmem) inMem[inHostAddr] <= IN_W'(host_wdata);
   end

   // The word is read in the accept cycle, before any same-cycle host write
   // lands, and then travels READ_LATENCY stages to the output.
   sirc_lat_pipe #(
      .DEPTH (READ_LATENCY),
      .WIDTH (IN_W)
   ) readPipe (
      .clk      (clk),
      .reset    (reset),
      .inValid  (inAccept),
      .inData   (inMem[inputMemoryReadAdd]),
      .outValid (inputMemoryReadDataValid),
      .outData  (inputMemoryReadData)
   );

   // ---------------- output memory ----------------
   always_ff @(posedge clk) begin
      if (outAccept) begin
         for (int b = 0; b < OUTMEM_BYTE_WIDTH; b++) begin
            if (outputMemoryWriteByteMask[b])
               outMem[outputMemoryWriteAdd][b*8 +: 8] <= outputMemoryWriteData[b*8 +: 8];
         end
      end
   end

   // ---------------- run flag and write counter ----------------
   // A host run write overrides a simultaneous userRunClear; setting run
   // restarts the count even if a write is accepted in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         userRunValue    <= 1'b0;
         out_write_count <= '0;
      end else begin
         if (hostWrRun)         userRunValue <= host_wdata[0];
         else if (userRunClear) userRunValue <= 1'b0;

         if (hostWrRun && host_wdata[0]) out_write_count <= '0;
         else if (outAccept)             out_write_count <= satInc(out_write_count);
      end
   end

   // ---------------- host read-back ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         host_rdata <= '0;
      end else if (hostRead) begin
         case (host_sel)
            HOST_INMEM:  host_rdata <= 32'(inMem[inHostAddr]);
            HOST_PARAM:  host_rdata <= params[host_addr[7:0]];
            HOST_OUTMEM: host_rdata <= 32'(outMem[outHostAddr]);
            default:     host_rdata <= {31'b0, userRunValue};
         endcase
      end
   end

endmodule

// File: tb/tb_sirc_user_port_responder.sv
module tb_sirc_user_port_responder;
   import sirc_port_pkg::*;

   localparam int RL = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        stall = 1'b0;
   logic        userRunValue;
   logic        userRunClear = 1'b0;
   logic        register32CmdReq = 1'b0;
   logic        register32CmdAck;
   logic [7:0]  register32Address = '0;
   logic        register32WriteEn = 1'b0;
   logic [31:0] register32WriteData = '0;
   logic        register32ReadDataValid;
   logic [31:0] register32ReadData;
   logic        inputMemoryReadReq = 1'b0;
   logic        inputMemoryReadAck;
   logic [16:0] inputMemoryReadAdd = '0;
   logic        inputMemoryReadDataValid;
   logic [7:0]  inputMemoryReadData;
   logic        outputMemoryWriteReq = 1'b0;
   logic        outputMemoryWriteAck;
   logic [12:0] outputMemoryWriteAdd = '0;
   logic [7:0]  outputMemoryWriteData = '0;
   logic [0:0]  outputMemoryWriteByteMask = '0;
   logic        host_en = 1'b0;
   logic        host_we = 1'b0;
   logic [1:0]  host_sel = '0;
   logic [16:0] host_addr = '0;
   logic [31:0] host_wdata = '0;
   logic [31:0] host_rdata;
   logic [15:0] out_write_count;

   sirc_user_port_responder #(
      .INMEM_BYTE_WIDTH     (1),
      .OUTMEM_BYTE_WIDTH    (1),
      .INMEM_ADDRESS_WIDTH  (17),
      .OUTMEM_ADDRESS_WIDTH (13),
      .READ_LATENCY         (RL)
   ) dut (
      .clk                       (clk),
      .reset                     (reset),
      .stall                     (stall),
      .userRunValue              (userRunValue),
      .userRunClear              (userRunClear),
      .register32CmdReq          (register32CmdReq),
      .register32CmdAck          (register32CmdAck),
      .register32Address         (register32Address),
      .register32WriteEn         (register32WriteEn),
      .register32WriteData       (register32WriteData),
      .register32ReadDataValid   (register32ReadDataValid),
      .register32ReadData        (register32ReadData),
      .inputMemoryReadReq        (inputMemoryReadReq),
      .inputMemoryReadAck        (inputMemoryReadAck),
      .inputMemoryReadAdd        (inputMemoryReadAdd),
      .inputMemoryReadDataValid  (inputMemoryReadDataValid),
      .inputMemoryReadData       (inputMemoryReadData),
      .outputMemoryWriteReq      (outputMemoryWriteReq),
      .outputMemoryWriteAck      (outputMemoryWriteAck),
      .outputMemoryWriteAdd      (outputMemoryWriteAdd),
      .outputMemoryWriteData     (outputMemoryWriteData),
      .outputMemoryWriteByteMask (outputMemoryWriteByteMask),
      .host_en                   (host_en),
      .host_we                   (host_we),
      .host_sel                  (host_sel),
      .host_addr                 (host_addr),
      .host_wdata                (host_wdata),
      .host_rdata                (host_rdata),
      .out_write_count           (out_write_count)
   );

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [7:0]  m_in  [1 << 17];
   logic [31:0] m_par [256];
   logic [31:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [31:0] par_q[$];
   int          par_cyc_q[$];
   int          cyc = 0;
   int          n_inval = 0;
   int          n_parval = 0;
   logic        prev_reset = 1'b1;
   logic        prev_stall = 1'b0;
   logic        exp_ack;

   initial for (int i = 0; i < 256; i++) m_par[i] = '0;

   always @(negedge clk) begin
      cyc++;
      exp_ack = prev_reset ? 1'b0 : !prev_stall;
      chk("ack_param",  {31'b0, register32CmdAck},     {31'b0, exp_ack});
      chk("ack_inmem",  {31'b0, inputMemoryReadAck},   {31'b0, exp_ack});
      chk("ack_outmem", {31'b0, outputMemoryWriteAck}, {31'b0, exp_ack});

      if (inputMemoryReadDataValid) begin
         n_inval++;
         if (exp_q.size() == 0) chk("inmem_spurious_valid", 32'd1, 32'd0);
         else begin
            chk("inmem_data", {24'b0, inputMemoryReadData}, exp_q.pop_front());
            chk("inmem_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
         chk("inmem_missing_valid", 32'd0, 32'd1);
         void'(exp_q.pop_front());
         void'(exp_cyc_q.pop_front());
      end

      if (register32ReadDataValid) begin
         n_parval++;
         if (par_q.size() == 0) chk("param_spurious_valid", 32'd1, 32'd0);
         else begin
            chk("param_data", register32ReadData, par_q.pop_front());
            chk("param_cycle", cyc, par_cyc_q.pop_front());
         end
      end
      while (par_cyc_q.size() > 0 && par_cyc_q[0] < cyc) begin
         chk("param_missing_valid", 32'd0, 32'd1);
         void'(par_q.pop_front());
         void'(par_cyc_q.pop_front());
      end

      if (reset) begin
         exp_q.delete(); exp_cyc_q.delete();
         par_q.delete(); par_cyc_q.delete();
         for (int i = 0; i < 256; i++) m_par[i] = '0;
      end else begin
         if (inputMemoryReadReq && inputMemoryReadAck) begin
            exp_q.push_back({24'b0, m_in[inputMemoryReadAdd]});
            exp_cyc_q.push_back(cyc + RL);
         end
         if (register32CmdReq && register32CmdAck) begin
            if (register32WriteEn) m_par[register32Address] = register32WriteData;
            else begin
               par_q.push_back(m_par[register32Address]);
               par_cyc_q.push_back(cyc + 1);
            end
         end
         if (host_en && host_we && host_sel == 2'd0) m_in[host_addr] = host_wdata[7:0];
         if (host_en && host_we && host_sel == 2'd1) m_par[host_addr[7:0]] = host_wdata;
      end
      prev_reset = reset;
      prev_stall = stall;
   end

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack;
      int n = 0;
      while (!(register32CmdAck && inputMemoryReadAck && outputMemoryWriteAck) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic host_wr(input logic [1:0] sel, input logic [16:0] a, input logic [31:0] d);
      host_en = 1'b1; host_we = 1'b1; host_sel = sel; host_addr = a; host_wdata = d;
      tick();
      host_en = 1'b0; host_we = 1'b0;
   endtask

   task automatic host_rd(input logic [1:0] sel, input logic [16:0] a, output logic [31:0] d);
      host_en = 1'b1; host_we = 1'b0; host_sel = sel; host_addr = a;
      tick();
      d = host_rdata;
      host_en = 1'b0;
   endtask

   task automatic user_par(input logic [7:0] a, input logic we, input logic [31:0] d);
      register32CmdReq = 1'b1; register32Address = a; register32WriteEn = we; register32WriteData = d;
      wait_ack();
      tick();
      register32CmdReq = 1'b0; register32WriteEn = 1'b0;
   endtask

   task automatic user_out(input logic [12:0] a, input logic [7:0] d, input logic m);
      outputMemoryWriteReq = 1'b1; outputMemoryWriteAdd = a;
      outputMemoryWriteData = d; outputMemoryWriteByteMask = m;
      wait_ack();
      tick();
      outputMemoryWriteReq = 1'b0;
   endtask

   // Streams n reads from address 0 upward with req held high; with
   // do_stall set, stall is high for loop cycles 10..14.
   task automatic stream(input int n, input logic do_stall, output int cycles);
      int   acc = 0;
      int   i = 0;
      int   v0 = n_inval;
      logic a;
      inputMemoryReadReq = 1'b1;
      inputMemoryReadAdd = '0;
      while (acc < n && i < 2000) begin
         stall = do_stall && i >= 10 && i <= 14;
         a = inputMemoryReadAck;
         tick();
         if (a) begin
            acc++;
            inputMemoryReadAdd = 17'(acc);
         end
         i++;
      end
      inputMemoryReadReq = 1'b0;
      stall = 1'b0;
      if (i >= 2000) chk("stream_timeout", 32'd0, 32'd1);
      repeat (RL + 2) tick();
      chk("stream_valid_count", n_inval - v0, n);
      cycles = i;
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] d;
   int          cycles;
   int          pv0;

   initial begin
      repeat (3) tick();
      chk("rst_host_rdata", host_rdata, 32'h0);
      chk("rst_run", {31'b0, userRunValue}, 32'h0);
      chk("rst_count", {16'b0, out_write_count}, 32'h0);
      chk("rst_par_rdata", register32ReadData, 32'h0);
      chk("rst_in_rdata", {24'b0, inputMemoryReadData}, 32'h0);
      chk("rst_par_valid", {31'b0, register32ReadDataValid}, 32'h0);
      chk("rst_in_valid", {31'b0, inputMemoryReadDataValid}, 32'h0);
      reset = 1'b0;
      tick();
      tick();

      // parameters: host writes, user reads back-to-back
      host_wr(2'd1, 17'd0, 32'h12345678);
      host_wr(2'd1, 17'd1, 32'hCAFEBABE);
      pv0 = n_parval;
      user_par(8'd0, 1'b0, 32'h0);
      user_par(8'd1, 1'b0, 32'h0);
      repeat (3) tick();
      chk("param_valid_count", n_parval - pv0, 32'd2);
      host_rd(2'd1, 17'd1, d);
      chk("host_param1", d, 32'hCAFEBABE);
      host_rd(2'd1, 17'h101, d);
      chk("host_param_wrap", d, 32'hCAFEBABE);

      // host and user write the same parameter together: host wins
      register32CmdReq = 1'b1; register32Address = 8'd9;
      register32WriteEn = 1'b1; register32WriteData = 32'h11111111;
      host_en = 1'b1; host_we = 1'b1; host_sel = 2'd1; host_addr = 17'd9; host_wdata = 32'h22222222;
      tick();
      register32CmdReq = 1'b0; register32WriteEn = 1'b0; host_en = 1'b0; host_we = 1'b0;
      host_rd(2'd1, 17'd9, d);
      chk("param_collision", d, 32'h22222222);

      // input memory load and streaming read
      for (int i = 0; i < 512; i++) host_wr(2'd0, 17'(i), 32'(i & 8'hFF));
      host_rd(2'd0, 17'd300, d);
      chk("host_inmem300", d, 32'h2C);
      stream(512, 1'b0, cycles);
      chk("stream_cycles", cycles, 32'd512);
      stream(40, 1'b1, cycles);
      chk("stall_cycles", cycles, 32'd45);

      // host write and user read of the same word together: user gets old
      inputMemoryReadReq = 1'b1; inputMemoryReadAdd = 17'd3;
      host_en = 1'b1; host_we = 1'b1; host_sel = 2'd0; host_addr = 17'd3; host_wdata = 32'h77;
      tick();
      inputMemoryReadReq = 1'b0; host_en = 1'b0; host_we = 1'b0;
      repeat (RL + 1) tick();
      host_rd(2'd0, 17'd3, d);
      chk("inmem_after_collision", d, 32'h77);

      // run set, output writes, host read-back
      host_wr(2'd3, 17'd0, 32'h1);
      chk("run_set", {31'b0, userRunValue}, 32'h1);
      chk("count_cleared", {16'b0, out_write_count}, 32'h0);
      for (int i = 0; i < 32; i++) user_out(13'(i), 8'(8'hA0 + i), 1'b1);
      chk("count_32", {16'b0, out_write_count}, 32'd32);
      host_rd(2'd2, 17'd5, d);
      chk("host_outmem5", d, 32'hA5);
      host_rd(2'd2, 17'h2005, d);
      chk("host_outmem_wrap", d, 32'hA5);
      user_out(13'd6, 8'hFF, 1'b0);
      chk("count_masked", {16'b0, out_write_count}, 32'd33);
      host_rd(2'd2, 17'd6, d);
      chk("outmem_masked", d, 32'hA6);

      // host read and user write of the same word together: host gets old
      outputMemoryWriteReq = 1'b1; outputMemoryWriteAdd = 13'd7;
      outputMemoryWriteData = 8'h55; outputMemoryWriteByteMask = 1'b1;
      host_en = 1'b1; host_we = 1'b0; host_sel = 2'd2; host_addr = 17'd7;
      tick();
      d = host_rdata;
      outputMemoryWriteReq = 1'b0; host_en = 1'b0;
      chk("outmem_collision_old", d, 32'hA7);
      host_rd(2'd2, 17'd7, d);
      chk("outmem_collision_new", d, 32'h55);
      host_wr(2'd2, 17'd8, 32'hEE);
      host_rd(2'd2, 17'd8, d);
      chk("outmem_host_write_ignored", d, 32'hA8);
      chk("count_34", {16'b0, out_write_count}, 32'd34);

      // run clear, then clear and set together
      userRunClear = 1'b1;
      tick();
      userRunClear = 1'b0;
      chk("run_cleared", {31'b0, userRunValue}, 32'h0);
      host_rd(2'd3, 17'd0, d);
      chk("host_run_read", d, 32'h0);
      chk("count_kept", {16'b0, out_write_count}, 32'd34);
      userRunClear = 1'b1;
      host_en = 1'b1; host_we = 1'b1; host_sel = 2'd3; host_wdata = 32'h1;
      tick();
      userRunClear = 1'b0; host_en = 1'b0; host_we = 1'b0;
      chk("run_set_wins", {31'b0, userRunValue}, 32'h1);
      chk("count_set_clear", {16'b0, out_write_count}, 32'h0);

      // reset one cycle after an input-memory accept
      inputMemoryReadReq = 1'b1; inputMemoryReadAdd = 17'd10;
      wait_ack();
      tick();
      inputMemoryReadReq = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_in_valid", {31'b0, inputMemoryReadDataValid}, 32'h0);
      chk("mid_rst_run", {31'b0, userRunValue}, 32'h0);
      chk("mid_rst_host_rdata", host_rdata, 32'h0);
      chk("mid_rst_par_rdata", register32ReadData, 32'h0);
      repeat (3) tick();
      pv0 = n_parval;
      user_par(8'd1, 1'b0, 32'h0);
      repeat (2) tick();
      chk("post_rst_param_valid", n_parval - pv0, 32'd1);
      host_rd(2'd1, 17'd0, d);
      chk("post_rst_param0", d, 32'h0);

      repeat (5) tick();
      chk("inmem_queue_empty", exp_q.size(), 32'd0);
      chk("param_queue_empty", par_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
